uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter among NUM_REQ packet sources, such as coincidence-event reporters and status monitors.
- Round-robin arbitration at packet granularity: the owner keeps the UART until its byte flagged last has completed.
- Sequences each byte into uart_tx (tx_en pulse, wait for tx_done, wait for busy low).
- Releases a stalled owner after a timeout.
- Sits between the packet formatters and uart_tx.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 32'd5_000_000, idle-owner cycles before forced release (0.1 s at 50 MHz)
IDX_W, 3, width of the owner index (must be >= clog2(NUM_REQ))

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
req_last  in  NUM_REQ  byte is the last of its packet
req_ready  out  NUM_REQ  byte accepted this cycle (transfer = valid & ready)
grant  out  NUM_REQ  one-hot current owner; 0 when idle
owner_idx  out  IDX_W  index of current or last owner
uart_tx_en  out  1  one-cycle start pulse to uart_tx
uart_data  out  8  byte to uart_tx, stable from the pulse until the next pulse
uart_busy  in  1  uart_tx busy
uart_done  in  1  uart_tx tx_done pulse
timeout_err  out  1  one-cycle pulse on forced release
pkt_count  out  16  completed packets, wraps at 16'hFFFF -> 0

Behaviour:
Reset (rst sampled high on a clk edge):
- State returns to IDLE; the round-robin pointer is set to 0.
- All outputs clear to 0: grant, req_ready, uart_tx_en, uart_data, owner_idx, timeout_err, pkt_count.
- Reset mid-byte: uart_tx may still be shifting. IDLE does not grant while uart_busy=1, so no byte is corrupted.

State machine: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> WAIT_IDLE -> ISSUE or IDLE.
- IDLE:
  - Grants when uart_busy=0 and any req_valid=1.
  - Picks the first valid index scanning ptr, ptr+1, ... modulo NUM_REQ.
  - grant and owner_idx are registered and take effect on the next cycle, in state ISSUE.
- ISSUE:
  - req_ready[owner] = 1, combinational from state. All other req_ready bits are 0.
  - If req_valid[owner]=1: capture req_data and req_last; next cycle pulse uart_tx_en=1 with uart_data valid; go to WAIT_BUSY; clear the timeout counter.
  - Otherwise: increment the timeout counter. When it reaches TIMEOUT_CYC-1: pulse timeout_err, clear grant, set ptr=owner+1, go to IDLE. pkt_count is not incremented.
- WAIT_BUSY: wait for uart_busy=1 (2 cycles after uart_tx_en), then go to WAIT_DONE.
- WAIT_DONE: wait for uart_done=1, then go to WAIT_IDLE.
- WAIT_IDLE: wait for uart_busy=0.
  - If the captured last=0: go to ISSUE.
  - If last=1: increment pkt_count, set ptr=owner+1 modulo NUM_REQ, clear grant, go to IDLE.
- A new arbitration never starts in the same cycle as a release. There is always one IDLE cycle between packets.

Handshake rules:
- req_ready is high for at most one owner and only in ISSUE.
- At most one byte is accepted per UART frame.
- Non-owners wait with valid held; their data is ignored.
- A requester deasserting valid mid-packet is legal until the timeout.

Single requester: it is re-granted after one IDLE cycle.

Decomposition:
Shared package uart_pkg holds:
- State encoding localparams: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3, WAIT_IDLE=4.
- Default baud and clock constants shared with uart_tx.

One sub-module, rr_pick: combinational round-robin selector.
- Inputs: req vector, ptr.
- Outputs: one-hot select, index, any.
- Unit-tested separately.

Test Plan:
- Single packet: req0 sends 3 bytes {8'hA5, 8'h3C, 8'h81 last} -> three uart_tx_en pulses, each after the previous uart_done and busy-low; uart_data in order; pkt_count=1; grant returns to 0.
- Contention: req0, req1 and req3 valid simultaneously, one byte each (last=1) -> served in order 0, 1, 3; then req0 valid again while req3 is being served -> order continues 0 after 3; no overlap of uart_tx_en with uart_busy=1.
- Packet lock: req1 is sending a 4-byte packet while req2 is valid throughout -> grant[2] stays 0 until req1's fourth byte finishes; req2 is granted after one IDLE cycle.
- Timeout (TIMEOUT_CYC=100): req2 sends 1 byte, last=0, then drops valid -> timeout_err pulses exactly 100 cycles after entering ISSUE; pkt_count is unchanged; a pending req3 is granted next.
- Reset mid-byte: assert rst for 1 cycle while the owner's byte is shifting (uart_busy=1, uart_tx not reset) -> all outputs 0 next cycle; no uart_tx_en until uart_busy=0; the next grant goes to req0 (ptr=0).
- Wrap: run 65536 one-byte packets (or force pkt_count to 16'hFFFF) -> pkt_count rolls to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit path: arbiter state encoding and
// the default clock/baud relationship used by uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        WAIT_IDLE = 3'd4
    } arb_state_t;

    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned BAUD         = 115_200;
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request found scanning
// ptr, ptr+1, ... modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     sel,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        sel = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                sel[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ packet sources with packet-granular
// round-robin arbitration and a stalled-owner timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter logic [31:0] TIMEOUT_CYC = 32'd5_000_000,
    parameter int          IDX_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_W-1:0]     owner_idx,
    output logic                 uart_tx_en,
    output logic [7:0]           uart_data,
    input  logic                 uart_busy,
    input  logic                 uart_done,
    output logic                 timeout_err,
    output logic [15:0]          pkt_count,
    output arb_state_t           fsm_state
);

    // Handshake: a byte moves when req_valid[i] & req_ready[i] on a clock edge;
    // req_ready is only ever the owner's bit, and only in ISSUE.
    logic [IDX_W-1:0]   ptr;
    logic [31:0]        tmo_cnt;
    logic               last_q;
    logic [NUM_REQ-1:0] pick_sel;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;
    logic [IDX_W-1:0]   next_ptr;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .sel (pick_sel),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign req_ready   = (fsm_state == ISSUE) ? grant : '0;
    assign owner_valid = |(req_valid & grant);
    assign owner_last  = |(req_last & grant);
    assign next_ptr    = (owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx + IDX_W'(1);

    // grant is one-hot, so OR-ing the masked lanes yields the owner's byte.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) owner_data = owner_data | req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_state   <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            owner_idx   <= '0;
            uart_tx_en  <= 1'b0;
            uart_data   <= '0;
            timeout_err <= 1'b0;
            pkt_count   <= '0;
            tmo_cnt     <= '0;
            last_q      <= 1'b0;
        end else begin
            uart_tx_en  <= 1'b0;
            timeout_err <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    // Holding off while uart_busy protects a frame left over from a reset.
                    if (!uart_busy && pick_any) begin
                        grant     <= pick_sel;
                        owner_idx <= pick_idx;
                        tmo_cnt   <= '0;
                        fsm_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (owner_valid) begin
                        uart_data  <= owner_data;
                        last_q     <= owner_last;
                        uart_tx_en <= 1'b1;
                        tmo_cnt    <= '0;
                        fsm_state  <= WAIT_BUSY;
                    end else if (tmo_cnt == TIMEOUT_CYC - 32'd1) begin
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        ptr         <= next_ptr;
                        fsm_state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                WAIT_BUSY: begin
                    if (uart_busy) fsm_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (uart_done) fsm_state <= WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (!uart_busy) begin
                        if (last_q) begin
                            pkt_count <= pkt_count + 16'd1;
                            ptr       <= next_ptr;
                            grant     <= '0;
                            fsm_state <= IDLE;
                        end else begin
                            tmo_cnt   <= '0;
                            fsm_state <= ISSUE;
                        end
                    end
                end
                default: fsm_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: uart_tx responder model, per-requester
// byte feeders and a byte scoreboard keyed by {owner, data}.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 3;
    localparam int FRAME   = 10;
    localparam int BOUND   = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*8-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]   req_last  = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     owner_idx;
    logic                 uart_tx_en;
    logic [7:0]           uart_data;
    logic                 uart_busy = 1'b0;
    logic                 uart_done = 1'b0;
    logic                 timeout_err;
    logic [15:0]          pkt_count;
    arb_state_t           fsm_state;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (32'd100),
        .IDX_W       (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .owner_idx   (owner_idx),
        .uart_tx_en  (uart_tx_en),
        .uart_data   (uart_data),
        .uart_busy   (uart_busy),
        .uart_done   (uart_done),
        .timeout_err (timeout_err),
        .pkt_count   (pkt_count),
        .fsm_state   (fsm_state)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0]  src_q [NUM_REQ][$];
    logic [10:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // uart_tx stand-in: busy rises 2 cycles after the start pulse, lasts FRAME
    // cycles, done pulses in the last busy cycle. Deliberately not reset by rst.
    int m_dly  = 0;
    int m_left = 0;
    always @(posedge clk) begin
        uart_done <= 1'b0;
        if (m_dly != 0) begin
            m_dly <= m_dly - 1;
            if (m_dly == 1) begin
                uart_busy <= 1'b1;
                m_left    <= FRAME;
            end
        end else if (uart_busy) begin
            if (m_left == 2) uart_done <= 1'b1;
            if (m_left == 1) uart_busy <= 1'b0;
            m_left <= m_left - 1;
        end
        if (uart_tx_en) m_dly <= 1;
    end

    // Requester feeders: pop a byte on acceptance, present the next one.
    always @(posedge clk) begin
        logic [NUM_REQ-1:0] acc;
        logic [8:0] f;
        acc = req_valid & req_ready;
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                f = src_q[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = f[7:0];
                req_last[i]        = f[8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    end

    // Scoreboard: every start pulse must carry the next expected {owner, byte}.
    always @(negedge clk) begin
        if (uart_tx_en === 1'b1) begin
            check("busy_at_tx_en", 32'(uart_busy), 32'd0);
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("uart_byte", 32'({owner_idx, uart_data}), 32'(exp_q.pop_front()));
        end
    end

    task automatic send(input int r, input logic [7:0] d, input logic l);
        src_q[r].push_back({l, d});
        exp_q.push_back({3'(r), d});
    endtask

    task automatic wait_pkt(input logic [15:0] n, input string tag);
        int cyc = 0;
        while (pkt_count !== n && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(pkt_count), 32'(n));
    endtask

    task automatic wait_grant(input logic [NUM_REQ-1:0] g, input string tag);
        int cyc = 0;
        while (grant !== g && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(grant), 32'(g));
    endtask

    task automatic wait_busy(input logic level, input string tag);
        int cyc = 0;
        while (uart_busy !== level && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(uart_busy), 32'(level));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_tx_en"}, 32'(uart_tx_en), 32'd0);
        check({tag, "_data"}, 32'(uart_data), 32'd0);
        check({tag, "_owner"}, 32'(owner_idx), 32'd0);
        check({tag, "_terr"}, 32'(timeout_err), 32'd0);
        check({tag, "_pkts"}, 32'(pkt_count), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
    endtask

    initial begin
        int n;
        // Power-on reset.
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        // Single packet from req0.
        send(0, 8'hA5, 1'b0);
        send(0, 8'h3C, 1'b0);
        send(0, 8'h81, 1'b1);
        wait_pkt(16'd1, "single_pkts");
        check("single_grant_idle", 32'(grant), 32'd0);

        // Reset while idle to bring the pointer back to 0, then contention.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(0, 8'h11, 1'b1);
        send(1, 8'h22, 1'b1);
        send(3, 8'h33, 1'b1);
        wait_grant(4'b1000, "cont_grant3");
        send(0, 8'h44, 1'b1);
        wait_pkt(16'd4, "cont_pkts");

        // Packet lock: req2 waits through req1's four-byte packet.
        send(1, 8'hB0, 1'b0);
        send(1, 8'hB1, 1'b0);
        send(1, 8'hB2, 1'b0);
        send(1, 8'hB3, 1'b1);
        send(2, 8'hC0, 1'b1);
        wait_grant(4'b0010, "lock_grant1");
        n = 0;
        while (grant === 4'b0010 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("lock_gap_grant", 32'(grant), 32'd0);
        check("lock_gap_pkts", 32'(pkt_count), 32'd5);
        @(negedge clk);
        check("lock_next_grant", 32'(grant), 32'b0100);
        wait_pkt(16'd6, "lock_pkts");

        // Timeout: req2 stalls after a non-last byte, req3 is pending.
        send(2, 8'hD0, 1'b0);
        n = 0;
        while (uart_tx_en !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("tmo_tx_en", 32'(uart_tx_en), 32'd1);
        send(3, 8'hE0, 1'b1);
        wait_busy(1'b1, "tmo_busy_hi");
        wait_busy(1'b0, "tmo_busy_lo");
        n = 0;
        while (timeout_err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            if (n == 50) check("tmo_stall_ready", 32'(req_ready), 32'b0100);
        end
        check("tmo_latency", 32'(n), 32'd101);
        check("tmo_grant_clr", 32'(grant), 32'd0);
        check("tmo_pkts", 32'(pkt_count), 32'd6);
        @(negedge clk);
        check("tmo_pulse_end", 32'(timeout_err), 32'd0);
        check("tmo_next_grant", 32'(grant), 32'b1000);
        wait_pkt(16'd7, "tmo_after_pkts");

        // Reset while a byte is shifting; uart_tx keeps running.
        send(1, 8'hF1, 1'b1);
        wait_busy(1'b1, "rst_busy_hi");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared("midrst");
        send(0, 8'h55, 1'b1);
        send(1, 8'h66, 1'b1);
        n = 0;
        while (uart_busy === 1'b1 && n < BOUND) begin
            check("midrst_hold_tx_en", 32'(uart_tx_en), 32'd0);
            check("midrst_hold_grant", 32'(grant), 32'd0);
            @(negedge clk);
            n++;
        end
        wait_grant(4'b0001, "midrst_first_grant");
        wait_pkt(16'd2, "midrst_pkts");

        // Packet counter wrap.
        force dut.pkt_count = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_count;
        send(2, 8'h77, 1'b1);
        n = 0;
        while (pkt_count === 16'hFFFF && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("wrap_pkts", 32'(pkt_count), 32'd0);

        repeat (5) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
